// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: turns a length-prefixed byte stream into padded 512-bit blocks,
// emitted as big-endian 32-bit words with block/message end flags.
module sha256_msg_padder #(
    parameter int MAX_LEN_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 MSG_START,
    input  logic [MAX_LEN_W-1:0] MSG_LEN,
    input  logic [7:0]           IN_DATA,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [31:0]          W_DATA,
    output logic                 W_VALID,
    input  logic                 W_READY,
    output logic                 W_EOB,
    output logic                 W_EOM,
    output logic                 BUSY
);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD1, S_ZERO, S_LEN, S_DRAIN} state_t;

    localparam logic [MAX_LEN_W-1:0] ONE = 1;

    state_t               state, state_nxt;
    logic [MAX_LEN_W-1:0] len_q, bc;
    logic [5:0]           bp, bp_inc;
    logic [2:0]           lc;
    logic [23:0]          asm_q;
    logic [63:0]          bitlen;
    logic [5:0]           len_sh;
    logic [7:0]           len_byte, byte_val;
    logic                 place, stall, word_done;

    assign bp_inc    = bp + 6'd1;
    assign bitlen    = {{(61-MAX_LEN_W){1'b0}}, len_q, 3'b000};
    assign len_sh    = {~lc, 3'b000};
    assign len_byte  = bitlen[len_sh +: 8];
    // A word-completing byte must wait until the output register is free (or freeing now).
    assign stall     = (bp[1:0] == 2'd3) && W_VALID && !W_READY;
    assign word_done = place && (bp[1:0] == 2'd3);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (MSG_START) state_nxt = (MSG_LEN == '0) ? S_PAD1 : S_DATA;
            S_DATA:  if (place && bc == len_q - ONE) state_nxt = S_PAD1;
            S_PAD1,
            S_ZERO:  if (place) state_nxt = (bp_inc == 6'd56) ? S_LEN : S_ZERO;
            S_LEN:   if (place && &lc) state_nxt = S_DRAIN;
            S_DRAIN: if (W_VALID && W_READY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        IN_READY = 1'b0;
        place    = 1'b0;
        byte_val = 8'h00;
        BUSY     = (state != S_IDLE);
        case (state)
            S_DATA: begin
                IN_READY = !stall;
                place    = IN_VALID && !stall;
                byte_val = IN_DATA;
            end
            S_PAD1: begin
                place    = !stall;
                byte_val = 8'h80;
            end
            S_ZERO:  place = !stall;
            S_LEN: begin
                place    = !stall;
                byte_val = len_byte;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            len_q   <= '0;
            bc      <= '0;
            bp      <= '0;
            lc      <= '0;
            asm_q   <= '0;
            W_DATA  <= '0;
            W_VALID <= 1'b0;
            W_EOB   <= 1'b0;
            W_EOM   <= 1'b0;
        end else begin
            if (state == S_IDLE && MSG_START) begin
                len_q <= MSG_LEN;
                bc    <= '0;
                bp    <= '0;
                lc    <= '0;
            end
            if (W_VALID && W_READY) begin
                W_VALID <= 1'b0;
                W_EOB   <= 1'b0;
                W_EOM   <= 1'b0;
            end
            if (place) begin
                bp <= bp_inc;
                if (state == S_DATA) bc <= bc + ONE;
                if (state == S_LEN)  lc <= lc + 3'd1;
                case (bp[1:0])
                    2'd0: asm_q[23:16] <= byte_val;
                    2'd1: asm_q[15:8]  <= byte_val;
                    2'd2: asm_q[7:0]   <= byte_val;
                    default: ;
                endcase
            end
            if (word_done) begin
                W_DATA  <= {asm_q, byte_val};
                W_VALID <= 1'b1;
                W_EOB   <= &bp[5:2];
                W_EOM   <= (state == S_LEN) && &lc;
            end
        end
    end

endmodule
